div_dispatch_scheduler: RTL and testbench

- Front-end scheduler for the normalization divider bank.
- Accepts ray-direction requests over a valid/ready handshake and stamps each with the next one-hot sequence tag.
- Issues each request to one of DIV_COUNT dividers in round-robin order. Per-divider credits ensure the 2-deep per-divider reorder FIFOs downstream never overflow, and the in-flight window is capped at TAG_SIZE so no tag value is aliased.
- Provides a flush sequence that drains all outstanding work and restarts the tag sequence.

---
 rtl/div_dispatch_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_div_dispatch_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_dispatch_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_dispatch_scheduler
// Description : Front-end scheduler for the normalization divider bank.
//               Tags each accepted ray-direction request with a rotating
//               one-hot sequence tag and issues it round-robin to a divider
//               lane that has a free reorder-FIFO credit. A flush drains all
//               outstanding work and restarts the tag sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module div_dispatch_scheduler #(
    parameter int DIV_COUNT = 16,
    parameter int TAG_SIZE  = 32,
    parameter int DATA_W    = 96,
    parameter int CREDITS   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [DATA_W-1:0]             req_data,
    input  logic                          flush,
    output logic [DIV_COUNT-1:0]          div_start,
    output logic [DATA_W-1:0]             div_data,
    output logic [TAG_SIZE-1:0]           div_tag,
    input  logic [DIV_COUNT-1:0]          div_busy,
    input  logic [DIV_COUNT-1:0]          credit_ret,
    input  logic                          retire_valid,
    output logic [$clog2(TAG_SIZE+1)-1:0] inflight,
    output logic                          idle,
    output logic                          err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int IW = $clog2(TAG_SIZE + 1);
    localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_RESTART = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_credit [DIV_COUNT];
    logic [PW-1:0]         r_rr_ptr;
    logic [TAG_SIZE-1:0]   r_tag;
    logic [IW-1:0]         r_inflight;
    logic                  r_err;

    logic [DIV_COUNT-1:0]  w_elig;
    logic [DIV_COUNT-1:0]  w_cred_zero;
    logic [DIV_COUNT-1:0]  w_cred_err;
    logic                  w_found;
    logic [PW-1:0]         w_sel;
    logic [PW-1:0]         w_cand;
    logic                  w_accept;
    logic                  w_drained;
    logic                  w_ret_ok;
    logic                  w_ret_err;

    // Per-lane eligibility, credit bookkeeping and spurious-return detection.
    // A lane started last cycle is skipped because its busy flag may lag.
    for (genvar i = 0; i < DIV_COUNT; i++) begin : g_lane
        logic w_inc;
        logic w_dec;

        assign w_elig[i]      = !div_busy[i] && (r_credit[i] < CW'(CREDITS)) && !div_start[i];
        assign w_cred_zero[i] = (r_credit[i] == '0);
        assign w_cred_err[i]  = credit_ret[i] && w_cred_zero[i];
        assign w_inc          = w_accept && (w_sel == PW'(i));
        assign w_dec          = credit_ret[i] && !w_cred_zero[i];

        // Credit counter: +1 on issue to this lane, -1 on a valid return.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_credit[i] <= '0;
            end else if (w_inc && !w_dec) begin
                r_credit[i] <= r_credit[i] + CW'(1);
            end else if (!w_inc && w_dec) begin
                r_credit[i] <= r_credit[i] - CW'(1);
            end
        end
    end

    // Round-robin pick: first eligible lane at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 0; k < DIV_COUNT; k++) begin
            w_cand = PW'((int'(r_rr_ptr) + k) % DIV_COUNT);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_accept  = req_valid && req_ready;
    assign w_drained = (r_inflight == '0) && (&w_cred_zero);
    assign w_ret_ok  = retire_valid && ((r_inflight != '0) || w_accept);
    assign w_ret_err = retire_valid && (r_inflight == '0) && !w_accept;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and ready decode; flush is only honoured in RUN.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        case (r_state)
            ST_RUN: begin
                req_ready = w_found && (r_inflight < IW'(TAG_SIZE));
                if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    w_state_nxt = ST_RESTART;
                end
            end
            ST_RESTART: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Issue register: one-cycle start strobe; payload and tag hold between issues.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_start <= '0;
            div_data  <= '0;
            div_tag   <= '0;
        end else begin
            div_start <= w_accept ? (DIV_COUNT'(1) << w_sel) : '0;
            if (w_accept) begin
                div_data <= req_data;
                div_tag  <= r_tag;
            end
        end
    end

    // Tag rotation and round-robin pointer; both restart after a drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag    <= TAG_SIZE'(1);
            r_rr_ptr <= '0;
        end else if (r_state == ST_RESTART) begin
            r_tag    <= TAG_SIZE'(1);
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_tag    <= (r_tag << 1) | (r_tag >> (TAG_SIZE - 1));
            r_rr_ptr <= PW'((int'(w_sel) + 1) % DIV_COUNT);
        end
    end

    // In-flight window: accept and retire in the same cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
        end else if (w_accept && !w_ret_ok) begin
            r_inflight <= r_inflight + IW'(1);
        end else if (!w_accept && w_ret_ok) begin
            r_inflight <= r_inflight - IW'(1);
        end
    end

    // Sticky protocol error: retire or credit return with nothing outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_ret_err || (|w_cred_err)) begin
            r_err <= 1'b1;
        end
    end

    assign inflight = r_inflight;
    assign err      = r_err;
    assign idle     = (r_state == ST_RUN) && (r_inflight == '0);

endmodule
`default_nettype wire

// File: tb/tb_div_dispatch_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_div_dispatch_scheduler
// Description : Self-checking bench for div_dispatch_scheduler: directed
//               vector table, hand-written corner sequences and random
//               traffic, all compared against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_dispatch_scheduler;

    localparam int DIV  = 16;
    localparam int TAG  = 32;
    localparam int DW   = 96;
    localparam int CRED = 2;
    localparam int IW   = $clog2(TAG + 1);

    logic                 clk;
    logic                 reset;
    logic                 req_valid;
    logic                 req_ready;
    logic [DW-1:0]        req_data;
    logic                 flush;
    logic [DIV-1:0]       div_start;
    logic [DW-1:0]        div_data;
    logic [TAG-1:0]       div_tag;
    logic [DIV-1:0]       div_busy;
    logic [DIV-1:0]       credit_ret;
    logic                 retire_valid;
    logic [IW-1:0]        inflight;
    logic                 idle;
    logic                 err;

    div_dispatch_scheduler #(
        .DIV_COUNT (DIV),
        .TAG_SIZE  (TAG),
        .DATA_W    (DW),
        .CREDITS   (CRED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .flush        (flush),
        .div_start    (div_start),
        .div_data     (div_data),
        .div_tag      (div_tag),
        .div_busy     (div_busy),
        .credit_ret   (credit_ret),
        .retire_valid (retire_valid),
        .inflight     (inflight),
        .idle         (idle),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic s_rdy;

    // Reference model: plain counters and a mode number.
    int             m_cred [DIV];
    int             m_infl;
    int             m_tagpos;
    int             m_rr;
    int             m_mode;      // 0 run, 1 drain, 2 restart
    int             m_last;      // lane started last cycle, -1 none
    bit             m_err;
    logic [DIV-1:0] m_start;
    logic [TAG-1:0] m_tag;
    logic [DW-1:0]  m_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DIV; i++) m_cred[i] = 0;
        m_infl = 0; m_tagpos = 0; m_rr = 0; m_mode = 0; m_last = -1;
        m_err = 1'b0; m_start = '0; m_tag = '0; m_data = '0;
    endtask

    function automatic int m_pick(input logic [DIV-1:0] busy);
        for (int k = 0; k < DIV; k++) begin
            int lane;
            lane = (m_rr + k) % DIV;
            if (!busy[lane] && m_cred[lane] < CRED && lane != m_last) return lane;
        end
        return -1;
    endfunction

    function automatic bit m_ready(input logic [DIV-1:0] busy);
        return (m_mode == 0) && (m_infl < TAG) && (m_pick(busy) >= 0);
    endfunction

    // One clock of stimulus: check ready before the edge, outputs after it.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit fl,
                        input logic [DIV-1:0] busy, input logic [DIV-1:0] cr, input bit rt);
        bit             rdy, acc, drained;
        int             g, old;
        logic [DIV-1:0] one_l;
        logic [TAG-1:0] one_t;
        one_l = 1; one_t = 1;
        req_valid = v; req_data = d; flush = fl; div_busy = busy;
        credit_ret = cr; retire_valid = rt;
        #1;
        rdy = m_ready(busy);
        s_rdy = req_ready;
        chk("req_ready", req_ready, rdy);
        g   = m_pick(busy);
        acc = v && rdy;
        drained = (m_infl == 0);
        for (int i = 0; i < DIV; i++) if (m_cred[i] != 0) drained = 1'b0;
        for (int i = 0; i < DIV; i++) begin
            old = m_cred[i];
            if (cr[i] && old == 0) m_err = 1'b1;
            m_cred[i] = old + ((acc && g == i) ? 1 : 0) - ((cr[i] && old > 0) ? 1 : 0);
        end
        if (rt && m_infl == 0 && !acc) m_err = 1'b1;
        m_infl = m_infl + (acc ? 1 : 0) - ((rt && (m_infl > 0 || acc)) ? 1 : 0);
        case (m_mode)
            0: if (fl) m_mode = 1;
            1: if (drained) m_mode = 2;
            default: begin m_mode = 0; m_tagpos = 0; m_rr = 0; end
        endcase
        if (acc) begin
            m_start  = one_l << g;
            m_data   = d;
            m_tag    = one_t << m_tagpos;
            m_tagpos = (m_tagpos + 1) % TAG;
            m_rr     = (g + 1) % DIV;
            m_last   = g;
        end else begin
            m_start = '0;
            m_last  = -1;
        end
        @(posedge clk);
        #1;
        chk("div_start", div_start, m_start);
        chk("div_tag",   div_tag,   m_tag);
        chk("div_data",  div_data,  m_data);
        chk("inflight",  inflight,  m_infl);
        chk("err",       err,       m_err);
        chk("idle",      idle,      (m_mode == 0 && m_infl == 0));
    endtask

    task automatic do_reset();
        req_valid = 0; req_data = '0; flush = 0; div_busy = '0;
        credit_ret = '0; retire_valid = 0;
        reset = 1'b1;
        #2;
        chk("rst_start", div_start, 0);
        chk("rst_tag",   div_tag,   0);
        chk("rst_data",  div_data,  0);
        chk("rst_infl",  inflight,  0);
        chk("rst_err",   err,       0);
        chk("rst_idle",  idle,      1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    typedef struct {
        bit             v;
        logic [DIV-1:0] busy;
        logic [DIV-1:0] cr;
        bit             rt;
        bit             exp_rdy;
        logic [DIV-1:0] exp_start;
        logic [TAG-1:0] exp_tag;
        int             exp_infl;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic [DIV-1:0] cr;
        bit             rt;

        tbl[0] = '{1'b1, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0001, 1, 1};
        tbl[1] = '{1'b1, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0002, 2, 2};
        tbl[2] = '{1'b1, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0004, 4, 3};
        tbl[3] = '{1'b1, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0008, 8, 4};

        reset = 1'b1;
        model_reset();

        // Back-to-back issue after reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(tbl[i].v, rnd_data(), 1'b0, tbl[i].busy, tbl[i].cr, tbl[i].rt);
            chk("tbl_ready", s_rdy,     tbl[i].exp_rdy);
            chk("tbl_start", div_start, tbl[i].exp_start);
            chk("tbl_tag",   div_tag,   tbl[i].exp_tag);
            chk("tbl_infl",  inflight,  tbl[i].exp_infl);
        end

        // Fill every lane to its credit limit, then free lane 5 only.
        do_reset();
        for (int i = 0; i < 33; i++) step(1'b1, rnd_data(), 1'b0, '0, '0, 1'b0);
        chk("fill_33rd_ready", s_rdy, 0);
        chk("fill_infl", inflight, 32);
        step(1'b1, rnd_data(), 1'b0, '0, 16'h0020, 1'b1);
        step(1'b1, rnd_data(), 1'b0, '0, '0, 1'b0);
        chk("fill_lane5_start", div_start, 16'h0020);

        // Only lane 0 free: it alternates with the just-started exclusion.
        do_reset();
        step(1'b1, rnd_data(), 1'b0, 16'hFFFE, '0, 1'b0);
        chk("busy_first", div_start, 16'h0001);
        step(1'b1, rnd_data(), 1'b0, 16'hFFFE, '0, 1'b0);
        chk("busy_excl_ready", s_rdy, 0);
        step(1'b1, rnd_data(), 1'b0, 16'hFFFE, '0, 1'b0);
        chk("busy_second", div_start, 16'h0001);
        step(1'b1, rnd_data(), 1'b0, 16'hFFFE, '0, 1'b0);
        step(1'b1, rnd_data(), 1'b0, 16'hFFFE, '0, 1'b0);
        chk("busy_full_ready", s_rdy, 0);
        step(1'b1, rnd_data(), 1'b0, 16'hFFFE, 16'h0001, 1'b0);
        chk("busy_ret_ready", s_rdy, 0);
        step(1'b1, rnd_data(), 1'b0, 16'hFFFE, 16'h0001, 1'b0);
        chk("busy_acc_ret_ready", s_rdy, 1);
        step(1'b1, rnd_data(), 1'b0, 16'hFFFE, '0, 1'b0);
        chk("busy_excl2_ready", s_rdy, 0);
        step(1'b1, rnd_data(), 1'b0, 16'hFFFE, '0, 1'b0);
        chk("busy_third_ready", s_rdy, 1);
        step(1'b1, rnd_data(), 1'b0, 16'hFFFE, '0, 1'b0);
        chk("busy_cap_ready", s_rdy, 0);
        chk("busy_infl", inflight, 4);

        // Tag window cap and tag wrap; credits returned so only the cap binds.
        do_reset();
        for (int i = 0; i < TAG; i++) step(1'b1, rnd_data(), 1'b0, '0, m_start, 1'b0);
        step(1'b1, rnd_data(), 1'b0, '0, m_start, 1'b0);
        chk("cap_ready", s_rdy, 0);
        chk("cap_infl", inflight, TAG);
        step(1'b0, rnd_data(), 1'b0, '0, '0, 1'b1);
        step(1'b1, rnd_data(), 1'b0, '0, '0, 1'b0);
        chk("cap_reopen_ready", s_rdy, 1);
        chk("cap_wrap_tag", div_tag, 1);

        // Flush: drain, one restart cycle, then tags and pointer restart.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, rnd_data(), 1'b0, '0, '0, 1'b0);
        step(1'b0, rnd_data(), 1'b1, '0, '0, 1'b0);
        step(1'b1, rnd_data(), 1'b1, '0, 16'h0001, 1'b1);
        chk("drain_ready", s_rdy, 0);
        chk("drain_idle", idle, 0);
        step(1'b1, rnd_data(), 1'b0, '0, 16'h0002, 1'b1);
        step(1'b1, rnd_data(), 1'b0, '0, 16'h0004, 1'b1);
        step(1'b1, rnd_data(), 1'b0, '0, '0, 1'b0);
        chk("drain_done_ready", s_rdy, 0);
        step(1'b1, rnd_data(), 1'b0, '0, '0, 1'b0);
        chk("restart_ready", s_rdy, 0);
        step(1'b1, rnd_data(), 1'b0, '0, '0, 1'b0);
        chk("post_flush_ready", s_rdy, 1);
        chk("post_flush_start", div_start, 16'h0001);
        chk("post_flush_tag", div_tag, 1);

        // Protocol errors are sticky and leave counters untouched.
        do_reset();
        step(1'b0, rnd_data(), 1'b0, '0, '0, 1'b1);
        chk("err_retire", err, 1);
        chk("err_retire_infl", inflight, 0);
        step(1'b0, rnd_data(), 1'b0, '0, 16'h0008, 1'b0);
        step(1'b0, rnd_data(), 1'b0, '0, '0, 1'b0);
        chk("err_sticky", err, 1);
        do_reset();
        chk("err_cleared", err, 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cr = '0;
            for (int i = 0; i < DIV; i++)
                if (m_cred[i] > 0 && $urandom_range(0, 3) == 0) cr[i] = 1'b1;
            if ($urandom_range(0, 63) == 0) cr = cr | DIV'($urandom);
            rt = (m_infl > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 199) == 0,
                 DIV'($urandom & $urandom & $urandom), cr, rt);
            if (n == 1500) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
